// File: rtl/id_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_issue_scoreboard
// Purpose  : Decode/issue controller between fetch and EX. It holds one
//            fetched instruction, decodes it, and tracks in-flight register
//            writes in a per-GPR pending scoreboard. A held instruction is
//            issued only when none of its sources or its destination have a
//            write outstanding (RAW/WAW hazard check). Write-back clears
//            pending bits.
//
// Ports    : clk            - system clock, all state on rising edge
//            rst_n          - asynchronous active-low reset
//            if_valid       - fetch presents if_instr
//            if_instr[31:0] - [31:26]op [25:21]rs [20:16]rt [15:11]rd [15:0]imm
//            if_ready       - instruction accepted this cycle when if_valid
//            flush          - discard held instruction (branch redirect)
//            ex_valid       - issued instruction valid toward EX
//            ex_ready       - EX accepts this cycle
//            ex_rs, ex_rt   - source register address fields
//            ex_dest        - destination register address
//            ex_alu_control - 0001 R-type, 0010 addi, 0000 jump
//            ex_reg_write   - instruction writes ex_dest
//            ex_imm         - immediate (0 for R-type and jump)
//            wb_valid       - write-back completes this cycle
//            wb_addr        - register being written back
//            illegal_instr  - one-cycle pulse: unknown opcode dropped
//            stall_cycles   - saturating count of hazard-stall cycles
//
// Revision : 1.0 - initial release
// ============================================================================
module id_issue_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  output logic                   if_ready,
  input  logic                   flush,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [4:0]             ex_rs,
  output logic [4:0]             ex_rt,
  output logic [4:0]             ex_dest,
  output logic [3:0]             ex_alu_control,
  output logic                   ex_reg_write,
  output logic [15:0]            ex_imm,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_addr,
  output logic                   illegal_instr,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_JUMP  = 6'b000010;

  localparam logic [3:0] ALU_RTYPE = 4'b0001;
  localparam logic [3:0] ALU_ADDI  = 4'b0010;
  localparam logic [3:0] ALU_JUMP  = 4'b0000;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HELD  = 1'b1;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Hold register
  // --------------------------------------------------------------------------
  logic [0:0]  r_state;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_dest;
  logic [3:0]  r_alu;
  logic        r_reg_write;
  logic [15:0] r_imm;
  logic        r_use_rs;
  logic        r_use_rt;

  // --------------------------------------------------------------------------
  // Decode of the incoming instruction (used only on capture)
  // --------------------------------------------------------------------------
  logic [5:0]  w_op;
  logic        w_dec_legal;
  logic        w_dec_use_rs;
  logic        w_dec_use_rt;
  logic [4:0]  w_dec_dest;
  logic [3:0]  w_dec_alu;
  logic        w_dec_reg_write;
  logic [15:0] w_dec_imm;

  assign w_op = if_instr[31:26];

  always_comb begin
    w_dec_legal     = 1'b0;
    w_dec_use_rs    = 1'b0;
    w_dec_use_rt    = 1'b0;
    w_dec_dest      = 5'd0;
    w_dec_alu       = ALU_JUMP;
    w_dec_reg_write = 1'b0;
    w_dec_imm       = 16'd0;
    case (w_op)
      OP_RTYPE: begin
        w_dec_legal     = 1'b1;
        w_dec_use_rs    = 1'b1;
        w_dec_use_rt    = 1'b1;
        w_dec_dest      = if_instr[15:11];
        w_dec_alu       = ALU_RTYPE;
        w_dec_reg_write = 1'b1;
      end
      OP_ADDI: begin
        // For addi the rt field names the destination, not a source.
        w_dec_legal     = 1'b1;
        w_dec_use_rs    = 1'b1;
        w_dec_dest      = if_instr[20:16];
        w_dec_alu       = ALU_ADDI;
        w_dec_reg_write = 1'b1;
        w_dec_imm       = if_instr[15:0];
      end
      OP_JUMP: begin
        w_dec_legal     = 1'b1;
        w_dec_alu       = ALU_JUMP;
      end
      default: begin
        w_dec_legal     = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Scoreboard: one pending bit per GPR. The vector is always 32 wide so a
  // 5-bit address can index it directly; untracked entries (r0 and anything
  // beyond NUM_REGS) read as constant zero.
  // --------------------------------------------------------------------------
  logic [31:0] w_pending;
  logic [31:0] w_set_vec;
  logic [31:0] w_clr_vec;

  logic w_held;
  logic w_hazard;
  logic w_issue;
  logic w_accept;

  assign w_held = (r_state == S_HELD);

  // Hazard looks only at the registered scoreboard, so a write-back clear
  // lifts a stall on the following cycle, never combinationally.
  assign w_hazard = (r_use_rs    && w_pending[r_rs])
                 || (r_use_rt    && w_pending[r_rt])
                 || (r_reg_write && w_pending[r_dest]);

  assign ex_valid = w_held && !w_hazard && !flush;
  assign w_issue  = ex_valid && ex_ready;

  // A new instruction may enter when the hold register is empty or is being
  // vacated by an issue this very cycle; rst_n gating keeps it low in reset.
  assign if_ready = rst_n && !flush && (!w_held || w_issue);
  assign w_accept = if_valid && if_ready;

  always_comb begin
    w_set_vec = 32'd0;
    w_clr_vec = 32'd0;
    if (w_issue && r_reg_write && (r_dest != 5'd0)) begin
      w_set_vec = 32'd1 << r_dest;
    end
    if (wb_valid && (wb_addr != 5'd0)) begin
      w_clr_vec = 32'd1 << wb_addr;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_sb
    if ((i == 0) || (i >= NUM_REGS)) begin : g_untracked
      assign w_pending[i] = 1'b0;
    end else begin : g_tracked
      logic r_pend;
      // Set has priority so a same-cycle issue and write-back of one
      // register leaves the new write outstanding.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pend <= 1'b0;
        end else if (w_set_vec[i]) begin
          r_pend <= 1'b1;
        end else if (w_clr_vec[i]) begin
          r_pend <= 1'b0;
        end
      end
      assign w_pending[i] = r_pend;
    end
  end

  // --------------------------------------------------------------------------
  // Hold-register state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_rs        <= 5'd0;
      r_rt        <= 5'd0;
      r_dest      <= 5'd0;
      r_alu       <= 4'd0;
      r_reg_write <= 1'b0;
      r_imm       <= 16'd0;
      r_use_rs    <= 1'b0;
      r_use_rt    <= 1'b0;
    end else begin
      if (flush) begin
        // Scoreboard is untouched: already-issued writes still return.
        r_state <= S_EMPTY;
      end else if (w_accept && w_dec_legal) begin
        r_state     <= S_HELD;
        r_rs        <= if_instr[25:21];
        r_rt        <= if_instr[20:16];
        r_dest      <= w_dec_dest;
        r_alu       <= w_dec_alu;
        r_reg_write <= w_dec_reg_write;
        r_imm       <= w_dec_imm;
        r_use_rs    <= w_dec_use_rs;
        r_use_rt    <= w_dec_use_rt;
      end else if (w_issue) begin
        // Covers both plain issue and issue alongside an illegal capture.
        r_state <= S_EMPTY;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Illegal-opcode pulse and hazard-stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= w_accept && !w_dec_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (w_held && w_hazard && !flush && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + STALL_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // EX-side fields come straight from the hold register, so they are stable
  // for as long as the instruction waits for ex_ready.
  // --------------------------------------------------------------------------
  assign ex_rs          = r_rs;
  assign ex_rt          = r_rt;
  assign ex_dest        = r_dest;
  assign ex_alu_control = r_alu;
  assign ex_reg_write   = r_reg_write;
  assign ex_imm         = r_imm;

endmodule

`default_nettype wire

// File: tb/tb_id_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_issue_scoreboard
// Purpose  : Self-checking bench for id_issue_scoreboard. A behavioural model
//            predicts the hold/pending/stall state; predicted issues go into a
//            queue that a separate monitor matches against observed handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [3:0]  ex_alu_control;
  logic        ex_reg_write;
  logic [15:0] ex_imm;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic        illegal_instr;
  logic [15:0] stall_cycles;

  id_issue_scoreboard #(.NUM_REGS(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_alu_control(ex_alu_control), .ex_reg_write(ex_reg_write), .ex_imm(ex_imm),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .illegal_instr(illegal_instr), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    bit legal; bit use_rs; bit use_rt; bit wr;
    int rs; int rt; int dest; int alu; int imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '{default: 0};
    d.rs = int'(ins[25:21]);
    d.rt = int'(ins[20:16]);
    case (ins[31:26])
      6'd0: begin d.legal = 1; d.use_rs = 1; d.use_rt = 1; d.wr = 1;
                  d.dest = int'(ins[15:11]); d.alu = 1; end
      6'd1: begin d.legal = 1; d.use_rs = 1; d.wr = 1;
                  d.dest = int'(ins[20:16]); d.alu = 2; d.imm = int'(ins[15:0]); end
      6'd2: begin d.legal = 1; end
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  bit   m_held;
  dec_t m_ins;
  bit   m_pend [32];
  int   m_stall;
  bit   m_illegal;
  dec_t exp_q [$];

  function automatic bit model_hazard();
    return (m_ins.use_rs && m_pend[m_ins.rs]) || (m_ins.use_rt && m_pend[m_ins.rt])
        || (m_ins.wr && m_pend[m_ins.dest]);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    dec_t d;
    bit hz, iss, acc;
    if (!rst_n) begin
      m_held    <= 1'b0;
      m_stall   <= 0;
      m_illegal <= 1'b0;
      for (int k = 0; k < 32; k++) m_pend[k] <= 1'b0;
    end else begin
      hz  = m_held && model_hazard();
      iss = m_held && !hz && !flush && ex_ready;
      acc = if_valid && !flush && (!m_held || iss);
      d   = decode(if_instr);
      if (iss) exp_q.push_back(m_ins);
      if (hz && !flush && m_stall < 65535) m_stall <= m_stall + 1;
      if (wb_valid && wb_addr != 5'd0) m_pend[wb_addr] <= 1'b0;
      if (iss && m_ins.wr && m_ins.dest != 0) m_pend[m_ins.dest] <= 1'b1;
      m_illegal <= acc && !d.legal;
      if (acc && d.legal) begin
        m_held <= 1'b1;
        m_ins  <= d;
      end else if (flush || iss) begin
        m_held <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / checker
  // --------------------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;
  bit sat_req = 1'b0;
  bit fin_req = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_rec(input string tag, input dec_t e, input dec_t a);
    if (e.use_rs) chk({tag, "_rs"}, a.rs, e.rs);
    if (e.use_rt) chk({tag, "_rt"}, a.rt, e.rt);
    if (e.wr)     chk({tag, "_dest"}, a.dest, e.dest);
    chk({tag, "_alu"}, a.alu, e.alu);
    chk({tag, "_reg_write"}, a.wr, e.wr);
    chk({tag, "_imm"}, a.imm, e.imm);
  endtask

  dec_t obs_q [$];

  always @(negedge clk) begin : monitor
    dec_t act, e, o;
    bit ev, ir;
    ev = m_held && !model_hazard() && !flush;
    ir = rst_n && !flush && (!m_held || (ev && ex_ready));
    chk("ex_valid", ex_valid, ev);
    chk("if_ready", if_ready, ir);
    chk("illegal_instr", illegal_instr, m_illegal);
    chk("stall_cycles", stall_cycles, m_stall);
    if (!rst_n) begin
      chk("rst_ex_fields", {ex_rs, ex_rt, ex_dest, ex_alu_control, ex_reg_write, ex_imm}, 0);
    end
    act = '{default: 0};
    act.rs = int'(ex_rs); act.rt = int'(ex_rt); act.dest = int'(ex_dest);
    act.alu = int'(ex_alu_control); act.wr = ex_reg_write; act.imm = int'(ex_imm);
    if (ex_valid && m_held) cmp_rec("held", m_ins, act);
    if (ex_valid && ex_ready) obs_q.push_back(act);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      cmp_rec("issue", e, o);
    end
    if (sat_req) chk("stall_saturated", stall_cycles, 16'hFFFF);
    if (fin_req) begin
      chk("issue_count", obs_q.size(), exp_q.size());
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {6'd1, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    if_valid = 1'b1;
    if_instr = ins;
    step();
    if_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset while holding a stalled reader of pending r5.
    ex_ready = 1'b1;
    send(addi(5'd0, 5'd5, 16'd3));
    send(rtype(5'd5, 5'd5, 5'd6));
    repeat (2) step();
    #2 rst_n = 1'b0;
    repeat (2) step();
    #2 rst_n = 1'b1;
    step();
    send(rtype(5'd5, 5'd0, 5'd6));   // r5 no longer pending: issues at once
    step();
    wb(5'd6);

    // RAW: add r3=r1+r2 then addi r4=r3+7, released by wb r3.
    send(rtype(5'd1, 5'd2, 5'd3));
    send(addi(5'd3, 5'd4, 16'h0007));
    repeat (4) step();
    wb(5'd3);
    step();
    wb(5'd4);

    // Writes to r0 never create a hazard.
    send(rtype(5'd5, 5'd6, 5'd0));
    send(rtype(5'd0, 5'd0, 5'd7));
    step();
    wb(5'd7);

    // EX back-pressure for 3 cycles on a jump.
    ex_ready = 1'b0;
    send({6'd2, 26'h2abcdef});
    repeat (2) step();
    ex_ready = 1'b1;
    step();

    // Illegal opcode 000011.
    send({6'd3, 26'h1234567});
    step();

    // Flush while stalled on r9; r9 stays pending until its write-back.
    send(addi(5'd0, 5'd9, 16'd1));
    send(rtype(5'd9, 5'd1, 5'd2));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    send(rtype(5'd9, 5'd0, 5'd10));
    repeat (3) step();
    wb(5'd9);
    step();
    wb(5'd10);

    // Randomised traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      if_valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: if_instr = rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)));
        1: if_instr = addi(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           16'($urandom));
        2: if_instr = {6'd2, 26'($urandom)};
        default: begin
          op = 6'($urandom_range(3, 63));
          if_instr = {op, 26'($urandom)};
        end
      endcase
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_addr  = 5'($urandom_range(0, 7));
      step();
    end
    if_valid = 1'b0;
    wb_valid = 1'b0;
    ex_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int r = 1; r < 32; r++) wb(5'(r));

    // Stall-counter saturation: 2^16+5 stall cycles on r9.
    send(addi(5'd0, 5'd9, 16'd2));
    send(rtype(5'd9, 5'd0, 5'd3));
    repeat (65541) step();
    sat_req = 1'b1;
    step();
    sat_req = 1'b0;
    wb(5'd9);
    step();
    wb(5'd3);
    repeat (3) step();
    fin_req = 1'b1;
    repeat (5) step();
    $display("FAIL timeout: monitor did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
